// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage sequencer. It runs a held request/ready handshake
// with a variable-latency data memory and freezes the front of the pipeline
// while the access is outstanding. It also captures load data for MEM/WB,
// flags timeouts, and counts stall cycles.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemReadIn,
  input  logic             MemWriteIn,
  input  logic [31:0]      AddrIn,
  input  logic [31:0]      WriteDataIn,
  output logic             MemReq,
  output logic             MemWe,
  output logic [31:0]      MemAddr,
  output logic [31:0]      MemWdata,
  input  logic             MemReady,
  input  logic [31:0]      MemRdata,
  output logic             Stall,
  output logic             Bubble,
  output logic [31:0]      ReadDataOut,
  output logic             MemError,
  output logic [CNT_W-1:0] StallCycles
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } stateT;

  // Last wait-counter value before the timeout fires. ACCESS lasts at most
  // TIMEOUT cycles, so together with the issue cycle Stall is high for at
  // most TIMEOUT+1 cycles.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  stateT            stateReg, stateNext;
  logic [7:0]       waitReg, waitNext;
  logic             storeReg, storeNext;
  logic [31:0]      rdataReg, rdataNext;
  logic             errReg, errNext;
  logic [CNT_W-1:0] stallCntReg;
  logic             access;

  // A simultaneous read and write is treated as a store.
  assign access = MemReadIn | MemWriteIn;

  // The address and data pass straight through. EX/MEM is frozen while the
  // request is held, so both stay stable.
  assign MemAddr     = AddrIn;
  assign MemWdata    = WriteDataIn;
  assign Bubble      = Stall;
  assign ReadDataOut = rdataReg;
  assign MemError    = errReg;
  assign StallCycles = stallCntReg;

  // Next-state and handshake outputs. MemReq, MemWe and Stall depend only on
  // the state and the EX/MEM controls, never on MemReady, so there is no
  // combinational loop through the memory.
  always_comb begin
    stateNext = stateReg;
    waitNext  = waitReg;
    storeNext = storeReg;
    rdataNext = rdataReg;
    errNext   = errReg;
    MemReq    = 1'b0;
    MemWe     = 1'b0;
    Stall     = 1'b0;
    unique case (stateReg)
      IDLE: begin
        if (access) begin
          MemReq    = 1'b1;
          MemWe     = MemWriteIn;
          Stall     = 1'b1;
          storeNext = MemWriteIn;
          if (MemReady) begin
            if (!MemWriteIn) rdataNext = MemRdata;
            stateNext = DONE;
          end else begin
            waitNext  = 8'd0;
            stateNext = ACCESS;
          end
        end
      end
      ACCESS: begin
        MemReq = 1'b1;
        MemWe  = storeReg;
        Stall  = 1'b1;
        if (MemReady) begin
          if (!storeReg) rdataNext = MemRdata;
          stateNext = DONE;
        end else if (waitReg == WAIT_LAST) begin
          // Forced completion: return zero data and flag the error.
          rdataNext = 32'd0;
          errNext   = 1'b1;
          stateNext = DONE;
        end else begin
          waitNext = waitReg + 8'd1;
        end
      end
      DONE: begin
        // EX/MEM still holds the serviced instruction, so never reissue here.
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // State, capture and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= IDLE;
      waitReg  <= 8'd0;
      storeReg <= 1'b0;
      rdataReg <= 32'd0;
      errReg   <= 1'b0;
    end else begin
      stateReg <= stateNext;
      waitReg  <= waitNext;
      storeReg <= storeNext;
      rdataReg <= rdataNext;
      errReg   <= errNext;
    end
  end

  // Saturating count of cycles spent with the pipeline frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCntReg <= '0;
    end else if (Stall && !(&stallCntReg)) begin
      stallCntReg <= stallCntReg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: scoreboard bench for the MEM-stage sequencer, with a
// variable-latency memory model and a second narrow-counter instance.
`timescale 1ns/1ps
module tb_mem_stage_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemReadIn = 1'b0;
  logic        MemWriteIn = 1'b0;
  logic [31:0] AddrIn = 32'd0;
  logic [31:0] WriteDataIn = 32'd0;
  logic        MemReq, MemWe, MemReady;
  logic [31:0] MemAddr, MemWdata, MemRdata;
  logic        Stall, Bubble, MemError;
  logic [31:0] ReadDataOut;
  logic [15:0] StallCycles;

  logic        MemReq4, MemWe4, Stall4, Bubble4, MemError4;
  logic [31:0] MemAddr4, MemWdata4, ReadDataOut4;
  logic [3:0]  StallCycles4;

  int asserts = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
    .AddrIn(AddrIn), .WriteDataIn(WriteDataIn), .MemReq(MemReq), .MemWe(MemWe),
    .MemAddr(MemAddr), .MemWdata(MemWdata), .MemReady(MemReady), .MemRdata(MemRdata),
    .Stall(Stall), .Bubble(Bubble), .ReadDataOut(ReadDataOut), .MemError(MemError),
    .StallCycles(StallCycles)
  );

  mem_stage_ctrl #(.TIMEOUT(TO), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
    .AddrIn(AddrIn), .WriteDataIn(WriteDataIn), .MemReq(MemReq4), .MemWe(MemWe4),
    .MemAddr(MemAddr4), .MemWdata(MemWdata4), .MemReady(MemReady), .MemRdata(MemRdata),
    .Stall(Stall4), .Bubble(Bubble4), .ReadDataOut(ReadDataOut4), .MemError(MemError4),
    .StallCycles(StallCycles4)
  );

  // Memory model: ready after memLat cycles of held request (-1 = never).
  int          memLat = -1;
  logic [31:0] memData = 32'd0;
  int          reqCycles = 0;
  int          writeCount = 0;
  logic [31:0] lastWAddr = 32'd0;
  logic [31:0] lastWData = 32'd0;

  assign MemReady = MemReq && (memLat >= 0) && (reqCycles == memLat);
  assign MemRdata = MemReady ? memData : 32'hBAD0BAD0;

  always @(posedge clk) begin
    if (rst || !MemReq) reqCycles <= 0;
    else                reqCycles <= reqCycles + 1;
    if (!rst && MemReq && MemWe && MemReady) begin
      writeCount <= writeCount + 1;
      lastWAddr  <= MemAddr;
      lastWData  <= MemWdata;
    end
  end

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          stalls;
    int          we;
    int          tot;
    int          tot4;
  } expT;

  expT         sbq[$];
  logic [31:0] mRd = 32'd0;
  logic        mErr = 1'b0;
  int          mTot = 0;
  int          mTot4 = 0;
  int          mWrites = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    asserts++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one access (called just after a rising edge), predict its result,
  // then follow it through to its DONE cycle and score it.
  task automatic runAccess(input string tag, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] data, input int lat);
    expT e;
    int  stalls, reqs, wes, bubs, n;
    bit  ok;
    MemReadIn   = rd;
    MemWriteIn  = wr;
    AddrIn      = addr;
    WriteDataIn = wdata;
    memLat      = lat;
    memData     = data;
    ok       = (lat >= 0) && (lat <= TO);
    e.stalls = ok ? lat + 1 : TO + 1;
    if (!ok) begin
      mRd  = 32'd0;
      mErr = 1'b1;
    end else if (rd && !wr) begin
      mRd = data;
    end
    if (ok && wr) mWrites++;
    mTot  = (mTot + e.stalls > 65535) ? 65535 : mTot + e.stalls;
    mTot4 = (mTot4 + e.stalls > 15) ? 15 : mTot4 + e.stalls;
    e.rd   = mRd;
    e.err  = mErr;
    e.we   = wr ? e.stalls : 0;
    e.tot  = mTot;
    e.tot4 = mTot4;
    sbq.push_back(e);

    stalls = 0; reqs = 0; wes = 0; bubs = 0; n = 0;
    @(negedge clk);
    check({tag, "/addr"}, MemAddr, addr);
    check({tag, "/wdata"}, MemWdata, wdata);
    while (Stall && n < 100) begin
      stalls++;
      if (MemReq) reqs++;
      if (MemWe)  wes++;
      if (Bubble) bubs++;
      @(negedge clk);
      n++;
    end
    e = sbq.pop_front();
    check({tag, "/finished"}, n < 100, 1'b1);
    check({tag, "/stallLen"}, stalls, e.stalls);
    check({tag, "/reqLen"}, reqs, e.stalls);
    check({tag, "/bubbleLen"}, bubs, e.stalls);
    check({tag, "/weLen"}, wes, e.we);
    check({tag, "/doneReq"}, MemReq, 1'b0);
    check({tag, "/doneBubble"}, Bubble, 1'b0);
    check({tag, "/readData"}, ReadDataOut, e.rd);
    check({tag, "/memError"}, MemError, e.err);
    check({tag, "/stallCycles"}, StallCycles, e.tot);
    check({tag, "/stallCycles4"}, StallCycles4, e.tot4);
    check({tag, "/readData4"}, ReadDataOut4, e.rd);
    check({tag, "/writes"}, writeCount, mWrites);
    $display("txn %s rd=%0d wr=%0d addr=%08h lat=%0d stalls=%0d rdata=%08h err=%0d cnt=%0d",
             tag, rd, wr, addr, lat, stalls, ReadDataOut, MemError, StallCycles);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    MemReadIn  = 1'b0;
    MemWriteIn = 1'b0;
    memLat     = -1;
    @(posedge clk);
    #1;
  endtask

  // Global time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset/MemReq", MemReq, 1'b0);
    check("reset/MemWe", MemWe, 1'b0);
    check("reset/Stall", Stall, 1'b0);
    check("reset/Bubble", Bubble, 1'b0);
    check("reset/ReadDataOut", ReadDataOut, 32'd0);
    check("reset/MemError", MemError, 1'b0);
    check("reset/StallCycles", StallCycles, 16'd0);
    @(posedge clk);
    #1;

    runAccess("load40", 1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 3);
    idle();
    runAccess("store80", 1'b0, 1'b1, 32'h80, 32'h12345678, 32'h0, 0);
    check("store80/wAddr", lastWAddr, 32'h80);
    check("store80/wData", lastWData, 32'h12345678);
    idle();
    runAccess("b2bA", 1'b1, 1'b0, 32'h100, 32'h0, 32'hA5A50001, 1);
    runAccess("b2bB", 1'b1, 1'b0, 32'h104, 32'h0, 32'h5A5A0002, 1);
    idle();
    runAccess("rdwr", 1'b1, 1'b1, 32'h200, 32'hCAFEF00D, 32'h11112222, 2);
    idle();
    runAccess("timeout", 1'b1, 1'b0, 32'h300, 32'h0, 32'h33334444, -1);
    idle();
    runAccess("afterErr", 1'b1, 1'b0, 32'h304, 32'h0, 32'h55556666, 2);
    runAccess("edgeLat", 1'b1, 1'b0, 32'h308, 32'h0, 32'h77778888, TO);
    idle();

    // Reset during the second ACCESS cycle of a load that never completes.
    MemReadIn  = 1'b1;
    MemWriteIn = 1'b0;
    AddrIn     = 32'h400;
    memLat     = -1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    MemReadIn = 1'b0;
    mRd = 32'd0; mErr = 1'b0; mTot = 0; mTot4 = 0;
    @(negedge clk);
    check("rstMid/MemReq", MemReq, 1'b0);
    check("rstMid/Stall", Stall, 1'b0);
    check("rstMid/ReadDataOut", ReadDataOut, 32'd0);
    check("rstMid/MemError", MemError, 1'b0);
    check("rstMid/StallCycles", StallCycles, 16'd0);
    check("rstMid/StallCycles4", StallCycles4, 4'd0);
    @(posedge clk);
    #1;

    runAccess("fresh", 1'b1, 1'b0, 32'h500, 32'h0, 32'h0BADF00D, 0);
    for (int i = 0; i < 4; i++) begin
      runAccess($sformatf("sat%0d", i), 1'b1, 1'b0, 32'h600 + 32'(i * 4), 32'h0,
                32'h60000000 + 32'(i), TO);
    end
    for (int i = 0; i < 6; i++) begin
      runAccess($sformatf("rnd%0d", i), 1'b1, (i % 3) == 2, 32'h700 + 32'(i * 4),
                $urandom, $urandom, int'($urandom_range(0, TO + 1)));
      if (i % 2 == 1) idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
